softmax_r2b_converter: RTL and testbench

// Row-to-block converter downstream of the self-attention softmax stage. Captures one slice of softmax

---
 rtl/softmax_r2b_converter.sv | 204 ++++++++++++++++++++
 tb/tb_softmax_r2b_converter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_r2b_converter.sv
// softmax_r2b_converter
// Row-to-block converter that sits after the self-attention softmax stage.
// A slice of TOTAL_SOFTMAX_ROW rows (TILE_SIZE_SOFTMAX elements each) is
// captured by row index in any order. Once every row is present, the slice
// is re-emitted as BLOCK_SIZE x BLOCK_SIZE blocks. Row groups form the outer
// loop and column blocks the inner loop.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   internal_rst_n synchronous active-low soft reset (wins over all else)
//   in_valid       row tile present (no back-pressure on the input side)
//   row_idx        row index of in_data within the slice
//   in_data        element k at [k*WIDTH +: WIDTH]
//   out_valid      block present on out_data (high throughout DRAIN)
//   out_ready      downstream accepts the current block
//   out_data       element (r,c) at [(r*BLOCK_SIZE+c)*WIDTH +: WIDTH]
//   slice_last     final block of the slice is on out_data
//   busy           DRAIN in progress, incoming rows are dropped
//   err_overflow   (R2B_ERR_EN only) sticky: row offered during DRAIN
//   err_row_range  (R2B_ERR_EN only) sticky: row_idx out of range
//
// Optional feature macro: R2B_ERR_EN adds the two sticky error outputs.
// Without it, offending writes are still dropped, but silently.
module softmax_r2b_converter #(
  parameter int WIDTH             = 16,
  parameter int TILE_SIZE_SOFTMAX = 8,
  parameter int TOTAL_SOFTMAX_ROW = 4,
  parameter int BLOCK_SIZE        = 2,
  localparam int RW = $clog2(TOTAL_SOFTMAX_ROW) + 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   internal_rst_n,
  input  logic                                   in_valid,
  input  logic [RW-1:0]                          row_idx,
  input  logic [WIDTH*TILE_SIZE_SOFTMAX-1:0]     in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] out_data,
  output logic                                   slice_last,
`ifdef R2B_ERR_EN
  output logic                                   err_overflow,
  output logic                                   err_row_range,
`endif
  output logic                                   busy
);

  localparam int CB_PER_ROW = TILE_SIZE_SOFTMAX / BLOCK_SIZE;
  localparam int NUM_BLOCKS = (TOTAL_SOFTMAX_ROW / BLOCK_SIZE) * CB_PER_ROW;
  localparam int CW         = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int TW         = WIDTH * TILE_SIZE_SOFTMAX;
  localparam int OW         = WIDTH * BLOCK_SIZE * BLOCK_SIZE;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                       state_r, state_nx_s;
  logic [TOTAL_SOFTMAX_ROW-1:0] mask_r, mask_nx_s;
  logic [CW-1:0]                cnt_r, cnt_nx_s;
  logic [TW-1:0]                buf_r [TOTAL_SOFTMAX_ROW];

  logic                         in_range_s;
  logic                         wr_ok_s;
  logic [TOTAL_SOFTMAX_ROW-1:0] row_oh_s;
  logic                         last_blk_s;
  logic [OW-1:0]                out_data_s;

  assign in_range_s = (row_idx < RW'(TOTAL_SOFTMAX_ROW));
  assign wr_ok_s    = in_valid && in_range_s && (state_r == FILL);
  assign last_blk_s = (cnt_r == CW'(NUM_BLOCKS - 1));

  // One-hot decode of the incoming row index (all zero when out of range).
  always_comb begin
    row_oh_s = {TOTAL_SOFTMAX_ROW{1'b0}};
    for (int i = 0; i < TOTAL_SOFTMAX_ROW; i++) begin
      if (row_idx == RW'(i)) begin
        row_oh_s[i] = 1'b1;
      end else begin
        row_oh_s[i] = 1'b0;
      end
    end
  end

  // Next-state logic for the FILL/DRAIN sequencer, row mask and block counter.
  always_comb begin
    state_nx_s = state_r;
    mask_nx_s  = mask_r;
    cnt_nx_s   = cnt_r;
    if (!internal_rst_n) begin
      state_nx_s = FILL;
      mask_nx_s  = {TOTAL_SOFTMAX_ROW{1'b0}};
      cnt_nx_s   = {CW{1'b0}};
    end else begin
      case (state_r)
        FILL: begin
          if (wr_ok_s) begin
            mask_nx_s = mask_r | row_oh_s;
            // The row that completes the mask also launches the drain.
            if (&mask_nx_s) begin
              state_nx_s = DRAIN;
            end else begin
              state_nx_s = FILL;
            end
          end else begin
            state_nx_s = FILL;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (last_blk_s) begin
              state_nx_s = FILL;
              mask_nx_s  = {TOTAL_SOFTMAX_ROW{1'b0}};
              cnt_nx_s   = {CW{1'b0}};
            end else begin
              cnt_nx_s = cnt_r + CW'(1);
            end
          end else begin
            cnt_nx_s = cnt_r;
          end
        end
        default: begin
          state_nx_s = FILL;
          mask_nx_s  = {TOTAL_SOFTMAX_ROW{1'b0}};
          cnt_nx_s   = {CW{1'b0}};
        end
      endcase
    end
  end

  // Sequencer state, row mask and block counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FILL;
      mask_r  <= {TOTAL_SOFTMAX_ROW{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      mask_r  <= mask_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Row buffer. Contents are not reset because the mask gates their use.
  always_ff @(posedge clk) begin
    if (internal_rst_n && wr_ok_s) begin
      for (int i = 0; i < TOTAL_SOFTMAX_ROW; i++) begin
        if (row_oh_s[i]) begin
          buf_r[i] <= in_data;
        end
      end
    end
  end

  // Block selection: cnt -> (row group, column block), gathered from the buffer.
  always_comb begin
    out_data_s = {OW{1'b0}};
    if (state_r == DRAIN) begin
      for (int r = 0; r < BLOCK_SIZE; r++) begin
        for (int c = 0; c < BLOCK_SIZE; c++) begin
          out_data_s[(r*BLOCK_SIZE+c)*WIDTH +: WIDTH] =
            buf_r[(int'(cnt_r) / CB_PER_ROW) * BLOCK_SIZE + r]
                 [((int'(cnt_r) % CB_PER_ROW) * BLOCK_SIZE + c) * WIDTH +: WIDTH];
        end
      end
    end else begin
      out_data_s = {OW{1'b0}};
    end
  end

  assign out_valid  = (state_r == DRAIN);
  assign busy       = (state_r == DRAIN);
  assign slice_last = (state_r == DRAIN) && last_blk_s;
  assign out_data   = out_data_s;

`ifdef R2B_ERR_EN
  logic err_overflow_r;
  logic err_row_range_r;

  // Sticky error flags. Only the hard and soft resets clear them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow_r  <= 1'b0;
      err_row_range_r <= 1'b0;
    end else if (!internal_rst_n) begin
      err_overflow_r  <= 1'b0;
      err_row_range_r <= 1'b0;
    end else begin
      if (in_valid && (state_r == DRAIN)) begin
        err_overflow_r <= 1'b1;
      end
      if (in_valid && (state_r == FILL) && !in_range_s) begin
        err_row_range_r <= 1'b1;
      end
    end
  end

  assign err_overflow  = err_overflow_r;
  assign err_row_range = err_row_range_r;
`endif

endmodule

// File: tb/tb_softmax_r2b_converter.sv
// Self-checking bench for softmax_r2b_converter (default parameters).
// A queue-based slice model predicts the block stream; a cycle table covers
// the basic in-order slice, and directed sequences cover reorder, stall,
// overflow, soft/hard reset and back-to-back slices, followed by random traffic.
module tb_softmax_r2b_converter;
  localparam int W  = 16;
  localparam int T  = 8;
  localparam int R  = 4;
  localparam int B  = 2;
  localparam int RW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            internal_rst_n;
  logic            in_valid;
  logic [RW-1:0]   row_idx;
  logic [W*T-1:0]  in_data;
  logic            out_ready;
  logic            out_valid;
  logic [W*B*B-1:0] out_data;
  logic            slice_last;
  logic            busy;
`ifdef R2B_ERR_EN
  logic            err_overflow;
  logic            err_row_range;
`endif

  softmax_r2b_converter dut (
    .clk(clk), .rst_n(rst_n), .internal_rst_n(internal_rst_n),
    .in_valid(in_valid), .row_idx(row_idx), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .slice_last(slice_last),
`ifdef R2B_ERR_EN
    .err_overflow(err_overflow), .err_row_range(err_row_range),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [W*T-1:0]   m_rows [R];
  logic [R-1:0]     m_wr;
  logic [W*B*B-1:0] m_q [$];
  logic             m_ov, m_rr;

  task automatic model_clear();
    m_q.delete();
    m_wr = '0;
    m_ov = 1'b0;
    m_rr = 1'b0;
  endtask

  // Slice is complete: enqueue every block in row-group-major order.
  task automatic model_build();
    logic [W*B*B-1:0] blk;
    for (int g = 0; g < R / B; g++)
      for (int cb = 0; cb < T / B; cb++) begin
        for (int r = 0; r < B; r++)
          for (int c = 0; c < B; c++)
            blk[(r*B+c)*W +: W] = m_rows[g*B+r][(cb*B+c)*W +: W];
        m_q.push_back(blk);
      end
  endtask

  task automatic model_edge(input logic iv, input int ridx, input logic [W*T-1:0] d,
                            input logic rdy, input logic srn);
    if (!srn) begin
      model_clear();
    end else if (m_q.size() == 0) begin
      if (iv) begin
        if (ridx < R) begin
          m_rows[ridx] = d;
          m_wr[ridx] = 1'b1;
          if (&m_wr) model_build();
        end else begin
          m_rr = 1'b1;
        end
      end
    end else begin
      if (iv) m_ov = 1'b1;
      if (rdy) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_wr = '0;
      end
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_q.size() != 0));
    chk({tag, ".busy"}, 64'(busy), 64'(m_q.size() != 0));
    chk({tag, ".slice_last"}, 64'(slice_last), 64'(m_q.size() == 1));
    if (m_q.size() != 0) chk({tag, ".out_data"}, 64'(out_data), 64'(m_q[0]));
`ifdef R2B_ERR_EN
    chk({tag, ".err_overflow"}, 64'(err_overflow), 64'(m_ov));
    chk({tag, ".err_row_range"}, 64'(err_row_range), 64'(m_rr));
`endif
  endtask

  // Drive one cycle's inputs (at negedge), take the edge, update the model.
  task automatic drive_edge(input logic iv, input int ridx, input logic [W*T-1:0] d,
                            input logic rdy, input logic srn);
    in_valid = iv; row_idx = RW'(ridx); in_data = d; out_ready = rdy; internal_rst_n = srn;
    @(posedge clk);
    model_edge(iv, ridx, d, rdy, srn);
    @(negedge clk);
  endtask

  task automatic step(input string tag, input logic iv, input int ridx,
                      input logic [W*T-1:0] d, input logic rdy, input logic srn);
    model_check(tag);
    drive_edge(iv, ridx, d, rdy, srn);
  endtask

  function automatic logic [W*T-1:0] pat_row(input int row, input int base);
    logic [W*T-1:0] v;
    for (int k = 0; k < T; k++) v[k*W +: W] = W'(base + row * 16 + k);
    return v;
  endfunction

  // Block n of a slice whose rows hold row*16+k, from plain arithmetic.
  function automatic logic [W*B*B-1:0] exp_blk(input int n);
    logic [W*B*B-1:0] v;
    int g, cb;
    g = n / (T / B);
    cb = n % (T / B);
    for (int r = 0; r < B; r++)
      for (int c = 0; c < B; c++)
        v[(r*B+c)*W +: W] = W'((g*B + r) * 16 + cb*B + c);
    return v;
  endfunction

  task automatic fill_slice(input string tag, input int base);
    for (int i = 0; i < R; i++) step(tag, 1'b1, i, pat_row(i, base), 1'b1, 1'b1);
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 0, '0, 1'b1, 1'b1);
  endtask

  typedef struct {
    logic           iv;
    int             ridx;
    logic           rdy;
    logic           e_valid;
    logic           e_last;
    logic [W*B*B-1:0] e_data;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // Table: in-order slice, then eight drain cycles and one idle.
    for (int i = 0; i < 13; i++) begin
      tbl[i].iv = (i < 4);
      tbl[i].ridx = (i < 4) ? i : 0;
      tbl[i].rdy = 1'b1;
      tbl[i].e_valid = (i >= 4 && i < 12);
      tbl[i].e_last = (i == 11);
      tbl[i].e_data = (i >= 4 && i < 12) ? exp_blk(i - 4) : '0;
    end

    rst_n = 1'b0; internal_rst_n = 1'b1; in_valid = 1'b0; row_idx = '0;
    in_data = '0; out_ready = 1'b0;
    model_clear();
    #12;
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.slice_last", 64'(slice_last), 64'd0);
    chk("reset.out_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: table-driven.
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("t1[%0d].out_valid", i), 64'(out_valid), 64'(tbl[i].e_valid));
      chk($sformatf("t1[%0d].busy", i), 64'(busy), 64'(tbl[i].e_valid));
      chk($sformatf("t1[%0d].slice_last", i), 64'(slice_last), 64'(tbl[i].e_last));
      if (tbl[i].e_valid)
        chk($sformatf("t1[%0d].out_data", i), 64'(out_data), 64'(tbl[i].e_data));
      drive_edge(tbl[i].iv, tbl[i].ridx, pat_row(tbl[i].ridx, 0), tbl[i].rdy, 1'b1);
    end

    // Test 2: out-of-order rows 3,1,0,2.
    step("t2", 1'b1, 3, pat_row(3, 0), 1'b1, 1'b1);
    step("t2", 1'b1, 1, pat_row(1, 0), 1'b1, 1'b1);
    step("t2", 1'b1, 0, pat_row(0, 0), 1'b1, 1'b1);
    step("t2", 1'b1, 2, pat_row(2, 0), 1'b1, 1'b1);
    chk("t2.first_block", 64'(out_data), 64'(exp_blk(0)));
    drain("t2", 9);

    // Test 3: stall three cycles on block 2.
    fill_slice("t3", 0);
    drain("t3", 2);
    for (int i = 0; i < 3; i++) begin
      chk("t3.hold_data", 64'(out_data), 64'(exp_blk(2)));
      step("t3", 1'b0, 0, '0, 1'b0, 1'b1);
    end
    drain("t3", 7);

    // Test 4: row 5 in FILL is dropped, row 1 during DRAIN is dropped.
    step("t4", 1'b1, 0, pat_row(0, 0), 1'b1, 1'b1);
    step("t4", 1'b1, 1, pat_row(1, 0), 1'b1, 1'b1);
    step("t4", 1'b1, 2, pat_row(2, 0), 1'b1, 1'b1);
    step("t4", 1'b1, 5, pat_row(3, 0), 1'b1, 1'b1);
    step("t4", 1'b1, 3, pat_row(3, 0), 1'b1, 1'b1);
    step("t4", 1'b1, 1, {8{16'hBEEF}}, 1'b1, 1'b1);
    for (int i = 1; i < 8; i++) begin
      chk("t4.block", 64'(out_data), 64'(exp_blk(i)));
      step("t4", 1'b0, 0, '0, 1'b1, 1'b1);
    end

    // Test 5a: soft reset while cnt=4, then a fresh slice.
    fill_slice("t5", 0);
    drain("t5", 4);
    step("t5", 1'b1, 2, '0, 1'b1, 1'b0);
    chk("t5.srst_valid", 64'(out_valid), 64'd0);
    chk("t5.srst_busy", 64'(busy), 64'd0);
    fill_slice("t5", 0);
    chk("t5.restart_blk0", 64'(out_data), 64'(exp_blk(0)));
    drain("t5", 9);

    // Test 5b: async reset mid-FILL clears the mask.
    step("t5b", 1'b1, 0, pat_row(0, 0), 1'b1, 1'b1);
    step("t5b", 1'b1, 1, pat_row(1, 0), 1'b1, 1'b1);
    rst_n = 1'b0;
    #2;
    model_clear();
    chk("t5b.async_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    step("t5b", 1'b1, 2, pat_row(2, 0), 1'b1, 1'b1);
    step("t5b", 1'b1, 3, pat_row(3, 0), 1'b1, 1'b1);
    chk("t5b.mask_cleared", 64'(out_valid), 64'd0);
    step("t5b", 1'b1, 0, pat_row(0, 0), 1'b1, 1'b1);
    step("t5b", 1'b1, 1, pat_row(1, 0), 1'b1, 1'b1);
    drain("t5b", 9);

    // Test 6: back-to-back slices.
    fill_slice("t6", 0);
    drain("t6", 8);
    fill_slice("t6", 100);
    chk("t6.slice2_blk0", 64'(out_data), 64'({16'd117, 16'd116, 16'd101, 16'd100}));
    drain("t6", 9);

    // Random traffic with occasional soft resets.
    for (int i = 0; i < 800; i++) begin
      step("rnd", ($urandom_range(0, 9) < 6), int'($urandom_range(0, 5)),
           {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
